// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF neuron: one update datapath shared round-robin by N_NEURONS virtual neurons.
// Latency: 2-cycle slot per neuron (read, write); a captured rise is serviced within 2*N_NEURONS+1 cycles.
// Backpressure: none; enable=0 parks the scheduler in S_READ while edge capture keeps running.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scheduler advances, 0 = hold before the next read
//   signal_in   : per-channel level inputs, synchronous to clk; rising edges become events
//   signal_out  : one-cycle spike pulse, bit i for neuron i
//   any_spike   : OR of signal_out, registered alongside it
//   frame_done  : one-cycle pulse after the last neuron's slot completes
//   dbg_idx     : neuron currently being serviced
//   dbg_v       : potential written by the most recent write slot (held between writes)
module lif_neuron_scheduler #(
    parameter int               N_NEURONS = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] THRESH    = WIDTH'(100),
    parameter logic [WIDTH-1:0] ADD       = WIDTH'(25),
    parameter logic [WIDTH-1:0] LEAK      = WIDTH'(1),
    parameter logic [WIDTH-1:0] VRESET    = WIDTH'(0),
    parameter int               REFRAC    = 2,
    localparam int              IW        = $clog2(N_NEURONS),
    localparam int              RW        = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_NEURONS-1:0] signal_in,
    output logic [N_NEURONS-1:0] signal_out,
    output logic                 any_spike,
    output logic                 frame_done,
    output logic [IW-1:0]        dbg_idx,
    output logic [WIDTH-1:0]     dbg_v
);

    typedef enum logic {S_READ, S_WRITE} state_t;

    state_t               state, state_nxt;
    logic                 do_read, do_write;

    logic [IW-1:0]        ptr;
    logic [WIDTH-1:0]     mem        [N_NEURONS];
    logic [RW-1:0]        refrac_cnt [N_NEURONS];
    logic [N_NEURONS-1:0] pending, pending_nxt, prev_in, rise;

    // Operands latched in S_READ, consumed in S_WRITE
    logic [WIDTH-1:0]     v_lat;
    logic                 took_lat;

    // Update datapath
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     integ, leaked, cand, v_new;
    logic                 refr, fire;
    logic [N_NEURONS-1:0] onehot;
    logic                 last;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_READ;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_read   = 1'b0;
        do_write  = 1'b0;
        case (state)
            S_READ: begin
                if (enable) begin
                    do_read   = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write slot always finishes so a neuron is never half-updated
                do_write  = 1'b1;
                state_nxt = S_READ;
            end
            default: state_nxt = S_READ;
        endcase
    end

    // ------------------------------------------------------------------
    // Edge capture and pending flags (run regardless of enable)
    // ------------------------------------------------------------------
    assign rise = signal_in & ~prev_in;

    always_comb begin
        pending_nxt = pending;
        if (do_read) pending_nxt[ptr] = 1'b0;
        // OR-ing rises after the clear lets a same-cycle rise survive for the next service
        pending_nxt = pending_nxt | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_in <= '0;
            pending <= '0;
        end else begin
            prev_in <= signal_in;
            pending <= pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Update arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        sum    = {1'b0, v_lat} + {1'b0, ADD};
        integ  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        leaked = (v_lat >= LEAK) ? (v_lat - LEAK) : '0;
        cand   = took_lat ? integ : leaked;
        refr   = (refrac_cnt[ptr] != '0);
        fire   = !refr && (cand >= THRESH);
        v_new  = (refr || fire) ? VRESET : cand;
        onehot = {{(N_NEURONS-1){1'b0}}, 1'b1} << ptr;
        last   = (ptr == IW'(N_NEURONS - 1));
    end

    // ------------------------------------------------------------------
    // Neuron state: pointer, latched operands, register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            v_lat    <= '0;
            took_lat <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i]        <= VRESET;
                refrac_cnt[i] <= '0;
            end
        end else begin
            if (do_read) begin
                v_lat    <= mem[ptr];
                took_lat <= pending[ptr];
            end
            if (do_write) begin
                mem[ptr] <= v_new;
                if (refr)      refrac_cnt[ptr] <= refrac_cnt[ptr] - RW'(1);
                else if (fire) refrac_cnt[ptr] <= RW'(REFRAC);
                ptr <= last ? '0 : ptr + IW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs: pulses last exactly one cycle after a write slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_out <= '0;
            any_spike  <= 1'b0;
            frame_done <= 1'b0;
            dbg_v      <= '0;
        end else begin
            signal_out <= '0;
            any_spike  <= 1'b0;
            frame_done <= 1'b0;
            if (do_write) begin
                signal_out <= fire ? onehot : '0;
                any_spike  <= fire;
                frame_done <= last;
                dbg_v      <= v_new;
            end
        end
    end

    assign dbg_idx = ptr;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
module tb_lif_neuron_scheduler;

    localparam int N      = 4;
    localparam int THRESH = 100;
    localparam int ADD    = 25;
    localparam int LEAK   = 1;
    localparam int VRESET = 0;
    localparam int REFRAC = 2;
    localparam int VMAX   = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] signal_in = '0;
    logic [3:0] signal_out;
    logic       any_spike, frame_done;
    logic [1:0] dbg_idx;
    logic [7:0] dbg_v;

    // Second instance with a saturating configuration
    logic       en2 = 1'b0;
    logic [3:0] sin2 = '0;
    logic [3:0] out2;
    logic       any2, fd2;
    logic [1:0] idx2;
    logic [7:0] v2;

    always #5 clk = ~clk;

    lif_neuron_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in),
        .signal_out(signal_out), .any_spike(any_spike), .frame_done(frame_done),
        .dbg_idx(dbg_idx), .dbg_v(dbg_v)
    );

    lif_neuron_scheduler #(.ADD(8'd200), .THRESH(8'd255)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(en2), .signal_in(sin2),
        .signal_out(out2), .any_spike(any2), .frame_done(fd2),
        .dbg_idx(idx2), .dbg_v(v2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-neuron integers, one service per two enabled steps
    // ------------------------------------------------------------------
    int m_mem [N];
    int m_ref [N];
    bit m_pend[N];
    bit m_prev[N];
    int m_ptr;
    bit m_in_write;
    int m_v;
    bit m_took;
    int e_out, e_fd, e_dbgv;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = VRESET; m_ref[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
        end
        m_ptr = 0; m_in_write = 0; m_v = 0; m_took = 0;
        e_out = 0; e_fd = 0; e_dbgv = 0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] sin);
        int nv;
        e_out = 0;
        e_fd  = 0;
        if (!m_in_write) begin
            if (en) begin
                m_v = m_mem[m_ptr];
                m_took = m_pend[m_ptr];
                m_pend[m_ptr] = 0;
                m_in_write = 1;
            end
        end else begin
            if (m_ref[m_ptr] > 0) begin
                nv = VRESET;
                m_ref[m_ptr]--;
            end else begin
                if (m_took) nv = (m_v + ADD > VMAX) ? VMAX : m_v + ADD;
                else        nv = (m_v >= LEAK) ? m_v - LEAK : 0;
                if (nv >= THRESH) begin
                    nv = VRESET;
                    m_ref[m_ptr] = REFRAC;
                    e_out = 1 << m_ptr;
                end
            end
            m_mem[m_ptr] = nv;
            e_dbgv = nv;
            e_fd = (m_ptr == N - 1) ? 1 : 0;
            m_ptr = (m_ptr + 1) % N;
            m_in_write = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (sin[i] && !m_prev[i]) m_pend[i] = 1;
            m_prev[i] = sin[i];
        end
    endtask

    // One clock: apply inputs, advance model, sample after the edge, compare
    task automatic cycle(input logic e, input logic [3:0] s);
        enable = e;
        signal_in = s;
        model_step(e, s);
        @(posedge clk);
        #1;
        chk("m_signal_out", int'(signal_out), e_out);
        chk("m_any_spike", int'(any_spike), (e_out != 0) ? 1 : 0);
        chk("m_frame_done", int'(frame_done), e_fd);
        chk("m_dbg_idx", int'(dbg_idx), m_ptr);
        chk("m_dbg_v", int'(dbg_v), e_dbgv);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; signal_in = '0; en2 = 1'b0; sin2 = '0;
        @(posedge clk);
        #1;
        chk("rst_signal_out", int'(signal_out), 0);
        chk("rst_any_spike", int'(any_spike), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_dbg_idx", int'(dbg_idx), 0);
        chk("rst_dbg_v", int'(dbg_v), 0);
        chk("rst_sat_out", int'({out2, any2, fd2, idx2, v2}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       en;
        logic [3:0] sin;
        logic [3:0] out;
        logic       fd;
        logic [1:0] idx;
        logic [7:0] v;
    } vec_t;

    vec_t tbl [17];
    int   exp2 [8];
    int   cnt;

    initial begin
        // Hold, capture while disabled, then one pass over all channels;
        // rows 14-15 drop enable during a write slot, which must still complete.
        tbl[0]  = '{1'b0, 4'b1111, 4'b0, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0, 1'b0, 2'd0, 8'd0};
        tbl[2]  = '{1'b0, 4'b0101, 4'b0, 1'b0, 2'd0, 8'd0};
        tbl[3]  = '{1'b1, 4'b0101, 4'b0, 1'b0, 2'd0, 8'd0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd1, 8'd25};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd1, 8'd25};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd2, 8'd25};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd2, 8'd25};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd3, 8'd25};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd3, 8'd25};
        tbl[10] = '{1'b1, 4'b0000, 4'b0, 1'b1, 2'd0, 8'd25};
        tbl[11] = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd0, 8'd25};
        tbl[12] = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd1, 8'd24};
        tbl[13] = '{1'b0, 4'b0000, 4'b0, 1'b0, 2'd1, 8'd24};
        tbl[14] = '{1'b1, 4'b0000, 4'b0, 1'b0, 2'd1, 8'd24};
        tbl[15] = '{1'b0, 4'b0000, 4'b0, 1'b0, 2'd2, 8'd24};
        tbl[16] = '{1'b0, 4'b0000, 4'b0, 1'b0, 2'd2, 8'd24};
        exp2 = '{0, 25, 50, 75, 0, 0, 0, 25};

        do_reset();
        for (int r = 0; r < 17; r++) begin
            cycle(tbl[r].en, tbl[r].sin);
            chk("tbl_out", int'(signal_out), int'(tbl[r].out));
            chk("tbl_fd", int'(frame_done), int'(tbl[r].fd));
            chk("tbl_idx", int'(dbg_idx), int'(tbl[r].idx));
            chk("tbl_v", int'(dbg_v), int'(tbl[r].v));
        end

        // One rise on ch0 per frame: 25,50,75, fire, two refractory services, then 25
        do_reset();
        for (int c = 0; c < 58; c++) begin
            cycle(1'b1, (c % 8 == 2 && c < 56) ? 4'b0001 : 4'b0000);
            if (c % 8 == 1) begin
                chk("t2_dbg_v", int'(dbg_v), exp2[c / 8]);
                chk("t2_spike", int'(signal_out), (c / 8 == 4) ? 1 : 0);
            end
        end

        // Single rise on ch1 then idle: leak down to zero and floor there
        do_reset();
        cnt = 0;
        for (int c = 0; c < 240; c++) begin
            cycle(1'b1, (c == 0) ? 4'b0010 : 4'b0000);
            if (any_spike) cnt++;
            if (c % 8 == 3) chk("t3_v1", int'(dbg_v), (25 - c / 8 > 0) ? 25 - c / 8 : 0);
        end
        chk("t3_no_spike", cnt, 0);

        // All channels reach threshold in the same frame
        do_reset();
        for (int c = 0; c < 41; c++) begin
            cycle(1'b1, (c % 8 == 7 && c < 32) ? 4'b1111 : 4'b0000);
            chk("t4_out", int'(signal_out),
                (c == 33) ? 1 : (c == 35) ? 2 : (c == 37) ? 4 : (c == 39) ? 8 : 0);
            chk("t4_fd", int'(frame_done), (c % 8 == 7) ? 1 : 0);
        end

        // Rise on ch2 in the very cycle its flag is consumed
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(1'b1, (c == 0 || c == 4) ? 4'b0100 : 4'b0000);
            if (c == 5)  chk("t5_first", int'(dbg_v), 25);
            if (c == 13) chk("t5_second", int'(dbg_v), 50);
        end

        // Saturating instance: 200, then 200+200 clamps to 255 and fires
        do_reset();
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            en2  = (c != 0);
            sin2 = (c == 0 || c == 3) ? 4'b0001 : 4'b0000;
            cycle(1'b0, 4'b0000);
            if (out2 != 0) cnt++;
            if (c == 2)  chk("t6_first", int'(v2), 200);
            if (c == 10) begin
                chk("t6_fire", int'(out2), 1);
                chk("t6_any", int'(any2), 1);
                chk("t6_reset_v", int'(v2), 0);
            end
        end
        chk("t6_fire_count", cnt, 1);

        // Asynchronous reset in the middle of a write slot
        do_reset();
        cycle(1'b0, 4'b0001);
        cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b0000);
        chk("t7_pre_v", int'(dbg_v), 25);
        cycle(1'b1, 4'b0000);
        rst_n = 1'b0;
        #2;
        chk("t7_async_v", int'(dbg_v), 0);
        chk("t7_async_idx", int'(dbg_idx), 0);
        chk("t7_async_out", int'({signal_out, any_spike, frame_done}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 4'b0001);
        cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b0000);
        chk("t7_mem_reset", int'(dbg_v), 25);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            cycle($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
